// File: rtl/alarm_controller_if.sv
// Button, timekeeping and display signals between the alarm sequencer and its surroundings.
// The master side drives buttons and the running time; the slave side (the controller) drives the alarm fields.
interface alarm_controller_if;
   logic       i_alarm_set;
   logic       i_arm;
   logic       i_snooze;
   logic       i_up;
   logic       i_down;
   logic       i_left;
   logic       i_right;
   logic       i_sec_tick;
   logic [4:0] i_hr;
   logic [5:0] i_min;
   logic [5:0] i_sec;
   logic [4:0] o_alarm_hr;
   logic [5:0] o_alarm_min;
   logic       o_sel;
   logic       o_setting;
   logic       o_armed;
   logic       o_ring;

   modport master (
      output i_alarm_set, i_arm, i_snooze, i_up, i_down, i_left, i_right,
      output i_sec_tick, i_hr, i_min, i_sec,
      input  o_alarm_hr, o_alarm_min, o_sel, o_setting, o_armed, o_ring
   );

   modport slave (
      input  i_alarm_set, i_arm, i_snooze, i_up, i_down, i_left, i_right,
      input  i_sec_tick, i_hr, i_min, i_sec,
      output o_alarm_hr, o_alarm_min, o_sel, o_setting, o_armed, o_ring
   );
endinterface

// File: rtl/alarm_controller.sv
// Alarm sequencer: hr:min alarm editing, match detection, ring/snooze/auto-silence timing.
// One cycle from button or trigger to registered outputs; buttons are single-cycle pulses, never stalled.
module alarm_controller #(
   parameter int RING_SECONDS   = 60,
   parameter int SNOOZE_SECONDS = 300
) (
   input logic                i_clk,
   input logic                i_rstn,
   alarm_controller_if.slave  bus
);

   typedef enum logic [2:0] {S_OFF, S_SET, S_ARMED, S_RING, S_SNOOZE} state_t;

   localparam logic [8:0] RING_LAST   = 9'(RING_SECONDS - 1);
   localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECONDS - 1);

   state_t     r_state;
   state_t     w_next;
   logic [4:0] r_alarm_hr;
   logic [5:0] r_alarm_min;
   logic       r_sel;
   logic       r_setting;
   logic       r_armed;
   logic       r_ring;
   logic [8:0] r_timer;
   logic       r_ret_armed;
   logic       r_match_d;

   logic w_match;
   logic w_trigger;
   logic w_ring_done;
   logic w_snooze_done;
   logic w_edit_inc;
   logic w_edit_dec;

   // Rising edge of the match, so arming inside the matching second never fires.
   assign w_match       = (bus.i_hr == r_alarm_hr) && (bus.i_min == r_alarm_min) && (bus.i_sec == 6'd0);
   assign w_trigger     = w_match && !r_match_d;
   assign w_ring_done   = bus.i_sec_tick && (r_timer == RING_LAST);
   assign w_snooze_done = bus.i_sec_tick && (r_timer == SNOOZE_LAST);
   assign w_edit_inc    = bus.i_up && !bus.i_down;
   assign w_edit_dec    = bus.i_down && !bus.i_up;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_OFF: begin
            if (bus.i_arm)            w_next = S_ARMED;
            else if (bus.i_alarm_set) w_next = S_SET;
         end
         S_ARMED: begin
            if (bus.i_arm)            w_next = S_OFF;
            else if (bus.i_alarm_set) w_next = S_SET;
            else if (w_trigger)       w_next = S_RING;
         end
         S_SET: begin
            if (bus.i_alarm_set)      w_next = r_ret_armed ? S_ARMED : S_OFF;
         end
         S_RING: begin
            if (bus.i_arm)            w_next = S_OFF;
            else if (bus.i_snooze)    w_next = S_SNOOZE;
            else if (w_ring_done)     w_next = S_ARMED;
         end
         S_SNOOZE: begin
            if (bus.i_arm)            w_next = S_OFF;
            else if (w_snooze_done)   w_next = S_RING;
         end
         default:                     w_next = S_OFF;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state     <= S_OFF;
         r_alarm_hr  <= '0;
         r_alarm_min <= '0;
         r_sel       <= 1'b0;
         r_setting   <= 1'b0;
         r_armed     <= 1'b0;
         r_ring      <= 1'b0;
         r_timer     <= '0;
         r_ret_armed <= 1'b0;
         r_match_d   <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_match_d <= w_match;
         r_setting <= (w_next == S_SET);
         r_armed   <= (w_next == S_ARMED) || (w_next == S_RING) || (w_next == S_SNOOZE);
         r_ring    <= (w_next == S_RING);

         if (w_next != r_state)
            r_timer <= '0;
         else if (bus.i_sec_tick && ((r_state == S_RING) || (r_state == S_SNOOZE)))
            r_timer <= r_timer + 9'd1;

         if ((r_state != S_SET) && (w_next == S_SET)) begin
            r_sel       <= 1'b0;
            r_ret_armed <= (r_state == S_ARMED);
         end

         // Edits use the field selected before any toggle in the same cycle.
         if (r_state == S_SET) begin
            if (bus.i_left || bus.i_right)
               r_sel <= !r_sel;
            if (r_sel) begin
               if (w_edit_inc)      r_alarm_hr <= (r_alarm_hr == 5'd23) ? 5'd0 : r_alarm_hr + 5'd1;
               else if (w_edit_dec) r_alarm_hr <= (r_alarm_hr == 5'd0) ? 5'd23 : r_alarm_hr - 5'd1;
            end else begin
               if (w_edit_inc)      r_alarm_min <= (r_alarm_min == 6'd59) ? 6'd0 : r_alarm_min + 6'd1;
               else if (w_edit_dec) r_alarm_min <= (r_alarm_min == 6'd0) ? 6'd59 : r_alarm_min - 6'd1;
            end
         end
      end
   end

   assign bus.o_alarm_hr  = r_alarm_hr;
   assign bus.o_alarm_min = r_alarm_min;
   assign bus.o_sel       = r_sel;
   assign bus.o_setting   = r_setting;
   assign bus.o_armed     = r_armed;
   assign bus.o_ring      = r_ring;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: table vectors, directed corner sequences, random run vs model.
module tb_alarm_controller;
   localparam int RING_S   = 60;
   localparam int SNOOZE_S = 300;

   localparam logic [6:0] B_SET = 7'b1000000;
   localparam logic [6:0] B_ARM = 7'b0100000;
   localparam logic [6:0] B_SNZ = 7'b0010000;
   localparam logic [6:0] B_UP  = 7'b0001000;
   localparam logic [6:0] B_DN  = 7'b0000100;
   localparam logic [6:0] B_LF  = 7'b0000010;
   localparam logic [6:0] B_RT  = 7'b0000001;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   alarm_controller_if bus ();

   alarm_controller #(.RING_SECONDS(RING_S), .SNOOZE_SECONDS(SNOOZE_S)) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int t_hr, t_min, t_sec;

   // Model: behaviour in terms of modes and elapsed seconds.
   int m_ahr, m_amin, m_cnt;
   bit m_sel, m_edit, m_armed, m_ring, m_snz, m_prev;

   typedef struct {
      logic [6:0]  btn;
      logic [14:0] exp;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [14:0] pack(int hr, int mn, bit sel, bit setting, bit armed, bit ring);
      return {5'(hr), 6'(mn), sel, setting, armed, ring};
   endfunction

   function automatic vec_t mk(logic [6:0] b, int hr, int mn, bit sel, bit setting, bit armed, bit ring);
      vec_t v;
      v.btn = b;
      v.exp = pack(hr, mn, sel, setting, armed, ring);
      return v;
   endfunction

   function automatic logic [14:0] dut_out();
      return {bus.o_alarm_hr, bus.o_alarm_min, bus.o_sel, bus.o_setting, bus.o_armed, bus.o_ring};
   endfunction

   function automatic logic [14:0] model_out();
      return pack(m_ahr, m_amin, m_sel, m_edit, m_armed && !m_edit, m_ring);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ahr = 0; m_amin = 0; m_cnt = 0;
      m_sel = 0; m_edit = 0; m_armed = 0; m_ring = 0; m_snz = 0; m_prev = 0;
   endtask

   task automatic model_step(input logic [6:0] b, input logic tk);
      bit set = b[6], arm = b[5], snz = b[4], up = b[3], dn = b[2], lr = b[1] | b[0];
      bit match = (t_hr == m_ahr) && (t_min == m_amin) && (t_sec == 0);
      bit trig = match && !m_prev;
      m_prev = match;
      if (m_edit) begin
         if (up && !dn) begin
            if (m_sel) m_ahr = (m_ahr + 1) % 24; else m_amin = (m_amin + 1) % 60;
         end
         if (dn && !up) begin
            if (m_sel) m_ahr = (m_ahr + 23) % 24; else m_amin = (m_amin + 59) % 60;
         end
         if (lr) m_sel = !m_sel;
         if (set) m_edit = 0;
      end else if (m_ring) begin
         if (arm) begin m_ring = 0; m_armed = 0; end
         else if (snz) begin m_ring = 0; m_snz = 1; m_cnt = 0; end
         else if (tk) begin
            m_cnt++;
            if (m_cnt == RING_S) m_ring = 0;
         end
      end else if (m_snz) begin
         if (arm) begin m_snz = 0; m_armed = 0; end
         else if (tk) begin
            m_cnt++;
            if (m_cnt == SNOOZE_S) begin m_snz = 0; m_ring = 1; m_cnt = 0; end
         end
      end else if (m_armed) begin
         if (arm) m_armed = 0;
         else if (set) begin m_edit = 1; m_sel = 0; end
         else if (trig) begin m_ring = 1; m_cnt = 0; end
      end else begin
         if (arm) m_armed = 1;
         else if (set) begin m_edit = 1; m_sel = 0; end
      end
   endtask

   task automatic set_time(input int h, input int m, input int s);
      t_hr = h; t_min = m; t_sec = s;
      bus.i_hr = 5'(h); bus.i_min = 6'(m); bus.i_sec = 6'(s);
   endtask

   task automatic set_sod(input int sod);
      set_time(sod / 3600, (sod / 60) % 60, sod % 60);
   endtask

   task automatic adv_sec();
      set_sod((t_hr * 3600 + t_min * 60 + t_sec + 1) % 86400);
   endtask

   // One clock: drive pulses, clock, advance the model, compare every output.
   task automatic step(input logic [6:0] b, input logic tk);
      {bus.i_alarm_set, bus.i_arm, bus.i_snooze, bus.i_up, bus.i_down, bus.i_left, bus.i_right} = b;
      bus.i_sec_tick = tk;
      @(posedge clk);
      #1;
      model_step(b, tk);
      chk("model", 32'(dut_out()), 32'(model_out()));
      {bus.i_alarm_set, bus.i_arm, bus.i_snooze, bus.i_up, bus.i_down, bus.i_left, bus.i_right} = '0;
      bus.i_sec_tick = 1'b0;
   endtask

   initial begin
      int rings;
      logic [6:0] b;
      bus.i_alarm_set = 0; bus.i_arm = 0; bus.i_snooze = 0; bus.i_up = 0;
      bus.i_down = 0; bus.i_left = 0; bus.i_right = 0; bus.i_sec_tick = 0;
      set_time(12, 0, 5);
      rstn = 1'b0;
      model_reset();
      #12 rstn = 1'b1;
      chk("reset_state", 32'(dut_out()), 32'(pack(0, 0, 0, 0, 0, 0)));

      // Edit sequence: set, down, left, up x7, set, then arm/disarm.
      tbl.push_back(mk(B_SET, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(B_DN, 0, 59, 0, 1, 0, 0));
      tbl.push_back(mk(B_LF, 0, 59, 1, 1, 0, 0));
      for (int i = 1; i <= 7; i++) tbl.push_back(mk(B_UP, i, 59, 1, 1, 0, 0));
      tbl.push_back(mk(B_SET, 7, 59, 1, 0, 0, 0));
      tbl.push_back(mk(B_ARM, 7, 59, 1, 0, 1, 0));
      tbl.push_back(mk(B_ARM, 7, 59, 1, 0, 0, 0));
      tbl.push_back(mk(B_SET, 7, 59, 0, 1, 0, 0));
      tbl.push_back(mk(B_UP | B_DN, 7, 59, 0, 1, 0, 0));
      tbl.push_back(mk(B_RT, 7, 59, 1, 1, 0, 0));
      tbl.push_back(mk(B_DN, 6, 59, 1, 1, 0, 0));
      tbl.push_back(mk(B_UP | B_SET, 7, 59, 1, 0, 0, 0));
      foreach (tbl[i]) begin
         step(tbl[i].btn, 1'b0);
         chk("table", 32'(dut_out()), 32'(tbl[i].exp));
      end

      // Program 07:30 and arm.
      step(B_SET, 0);
      repeat (29) step(B_DN, 0);
      step(B_SET, 0);
      step(B_ARM, 0);
      chk("armed_0730", 32'(dut_out()), 32'(pack(7, 30, 0, 0, 1, 0)));

      // Ring and auto-silence after RING_S ticks.
      set_time(7, 29, 59); step(0, 1);
      chk("no_ring_early", 32'(bus.o_ring), 32'(0));
      set_time(7, 30, 0); step(0, 1);
      chk("ring_on", 32'(bus.o_ring), 32'(1));
      for (int i = 1; i < RING_S; i++) begin adv_sec(); step(0, 1); end
      chk("ring_before_last", 32'(bus.o_ring), 32'(1));
      adv_sec(); step(0, 1);
      chk("auto_silence", 32'({bus.o_armed, bus.o_ring}), 32'(2'b10));

      // Snooze: SNOOZE_S-1 ticks silent, next tick re-rings.
      set_time(7, 29, 59); step(0, 0);
      set_time(7, 30, 0); step(0, 0);
      chk("ring_again", 32'(bus.o_ring), 32'(1));
      step(B_SNZ, 0);
      chk("snoozed", 32'({bus.o_armed, bus.o_ring}), 32'(2'b10));
      rings = 0;
      for (int i = 1; i < SNOOZE_S; i++) begin adv_sec(); step(0, 1); rings += int'(bus.o_ring); end
      chk("snooze_quiet", 32'(rings), 32'(0));
      adv_sec(); step(0, 1);
      chk("snooze_rering", 32'(bus.o_ring), 32'(1));

      // Arm beats snooze during ring.
      step(B_ARM | B_SNZ, 0);
      chk("dismiss", 32'({bus.o_setting, bus.o_armed, bus.o_ring}), 32'(0));

      // Arm inside the matching second: no fire.
      set_time(7, 29, 59); step(0, 0);
      set_time(7, 30, 0); step(B_ARM, 0);
      rings = 0;
      repeat (5) begin step(0, 0); rings += int'(bus.o_ring); end
      chk("arm_in_match", 32'({bus.o_armed, 1'(rings != 0)}), 32'(2'b10));

      // Match while editing, then leave edit still matching: no fire.
      step(B_SET, 0);
      set_time(7, 29, 59); step(0, 0);
      set_time(7, 30, 0);
      rings = 0;
      repeat (5) begin step(0, 0); rings += int'(bus.o_ring); end
      step(B_SET, 0);
      repeat (3) begin step(0, 0); rings += int'(bus.o_ring); end
      chk("set_in_match", 32'({bus.o_armed, 1'(rings != 0)}), 32'(2'b10));

      // Async reset mid-ring, between edges.
      set_time(7, 29, 59); step(0, 0);
      set_time(7, 30, 0); step(0, 0);
      chk("ring_pre_reset", 32'(bus.o_ring), 32'(1));
      #3 rstn = 1'b0;
      #1;
      chk("async_reset", 32'(dut_out()), 32'(0));
      model_reset();
      #2 rstn = 1'b1;
      step(0, 0);
      chk("after_reset", 32'(dut_out()), 32'(pack(0, 0, 0, 0, 0, 0)));

      // Random run against the model, with time often steered onto the alarm.
      for (int c = 0; c < 6000; c++) begin
         int r = $urandom_range(0, 99);
         logic tk = 1'b0;
         if (r < 3)      set_sod((m_ahr * 3600 + m_amin * 60 + 86399) % 86400);
         else if (r < 5) set_time(m_ahr, m_amin, 0);
         else if (r < 60) begin adv_sec(); tk = 1'b1; end
         b = '0;
         b[6] = ($urandom_range(0, 79) == 0);
         b[5] = ($urandom_range(0, 149) == 0);
         b[4] = ($urandom_range(0, 59) == 0);
         b[3] = ($urandom_range(0, 3) == 0);
         b[2] = ($urandom_range(0, 3) == 0);
         b[1] = ($urandom_range(0, 9) == 0);
         b[0] = ($urandom_range(0, 9) == 0);
         step(b, tk);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Alarm sequencer for the hr/min/sec timekeeping datapath. It holds a user-programmable alarm time (hr:min), which is edited with the same up/down/left/right buttons as the clock.
- Compares the alarm time against the running time and sequences ring, snooze and auto-silence timing.
- Timing is driven by the one-cycle seconds-carry pulse from the seconds counter.
- Sits beside the clock controller; drives the buzzer/LED and the alarm display fields.

Parameters:
RING_SECONDS, 60, seconds the alarm rings before auto-silence (1..511)
SNOOZE_SECONDS, 300, seconds of snooze before re-ring (1..511)

Ports:
i_clk  input  1  system clock, rising edge
i_rstn  input  1  reset, asynchronous, active-low
i_alarm_set  input  1  one-cycle pulse: enter/leave alarm-edit mode
i_arm  input  1  one-cycle pulse: arm/disarm; dismisses ring/snooze
i_snooze  input  1  one-cycle pulse: snooze while ringing
i_up  input  1  one-cycle pulse: increment selected field (edit mode)
i_down  input  1  one-cycle pulse: decrement selected field (edit mode)
i_left  input  1  one-cycle pulse: toggle selected field
i_right  input  1  one-cycle pulse: toggle selected field
i_sec_tick  input  1  one-cycle pulse per elapsed second (seconds carry)
i_hr  input  5  current hour, 0..23
i_min  input  6  current minute, 0..59
i_sec  input  6  current second, 0..59
o_alarm_hr  output  5  programmed alarm hour
o_alarm_min  output  6  programmed alarm minute
o_sel  output  1  edit field: 0=minute, 1=hour
o_setting  output  1  high in edit mode
o_armed  output  1  high in ARMED, RING, SNOOZE
o_ring  output  1  high in RING

Behaviour:
- Reset (async, i_rstn=0):
  - state=OFF, o_alarm_hr=0, o_alarm_min=0, o_sel=0.
  - o_setting=0, o_armed=0, o_ring=0.
  - timer=0, ret_armed=0, match_d=0.
  - Applies immediately and mid-operation from any state.
- All outputs are registered, decoded from the state and data registers.
- Timer: 9-bit counter. Cleared on every state transition. Increments on i_sec_tick in RING and SNOOZE only.
- Match definition: match = (i_hr==o_alarm_hr) && (i_min==o_alarm_min) && (i_sec==0).
- match_d <= match every cycle in every state. trigger = match & ~match_d.
  - Consequence: arming or leaving edit mode during the matching second does not fire the alarm.
- States: OFF, SET, ARMED, RING, SNOOZE.
- OFF:
  - i_arm -> ARMED.
  - i_alarm_set -> SET, with ret_armed<=0 and o_sel<=0.
- ARMED:
  - i_arm -> OFF.
  - i_alarm_set -> SET, with ret_armed<=1 and o_sel<=0.
  - otherwise trigger -> RING.
  - i_alarm_set beats trigger in the same cycle.
- SET:
  - i_left or i_right (either or both) toggles o_sel.
  - i_up alone increments the selected field; i_down alone decrements it.
  - i_up and i_down together: no change.
  - Wrap-around: minute 59->0 and 0->59; hour 23->0 and 0->23.
  - i_alarm_set -> ARMED if ret_armed else OFF.
  - i_arm and i_snooze are ignored. The alarm never fires in SET.
  - Field edits in the same cycle as i_alarm_set are still applied.
- RING (o_ring=1):
  - Priority: i_arm -> OFF; else i_snooze -> SNOOZE; else timer reaches RING_SECONDS on a tick -> ARMED (auto-silence, stays armed).
  - i_alarm_set, i_up, i_down, i_left, i_right are ignored.
- SNOOZE:
  - Priority: i_arm -> OFF; else timer reaches SNOOZE_SECONDS on a tick -> RING.
  - i_snooze is ignored. Match triggers are ignored.
- Latency:
  - Trigger, or the final tick, to o_ring change: 1 cycle.
  - Button pulse to o_setting, o_armed or field change: 1 cycle.
- Out-of-range inputs: i_hr/i_min never match an in-range alarm value. No clamping is required.

Test Plan:
- Reset then edit:
  - Stimulus: i_alarm_set; i_down x1; i_left; i_up x7; i_alarm_set.
  - Required: o_alarm_min=59, o_alarm_hr=7, o_sel toggles 0->1, o_setting=0 afterwards, o_armed=0.
- Ring and auto-silence:
  - Stimulus: alarm 07:30, armed; drive time 07:29:59 -> 07:30:00.
  - Required: o_ring=1 one cycle after i_sec=0; after 60 ticks o_ring=0 and o_armed=1.
- Snooze:
  - Stimulus: i_snooze while ringing; 299 ticks; then 1 more tick.
  - Required: o_ring stays 0 through 299 ticks; o_ring=1 one cycle after tick 300.
- Dismiss and priority:
  - Stimulus: i_arm and i_snooze asserted in the same cycle during RING.
  - Required: OFF, with o_ring=0 and o_armed=0.
- No spurious fire:
  - Stimulus: arm at 07:30:00 with alarm 07:30; separately, hold the match time while in SET.
  - Required: o_ring stays 0 in both cases.
- Async reset mid-ring:
  - Stimulus: pull i_rstn low between clock edges.
  - Required: all outputs reach reset values immediately; after release, state is OFF and the alarm time is 00:00.
